// File: rtl/wb_writer_pkg.sv
// Shared core definitions for the write-back stage: widths, register count
// and the write-back entry carried from each execution unit to the register file.
package wb_writer_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RAW  = 5;

    typedef logic [RAW-1:0]  reg_addr_t;
    typedef logic [XLEN-1:0] xdata_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        xdata_t    data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_t;

    // x0 is hardwired; an entry targeting it is retired without a write.
    function automatic logic writes_rf(input wb_entry_t e);
        return e.valid && (e.rd != '0);
    endfunction

endpackage

// File: rtl/wb_writer_hold_buf.sv
// One-entry holding buffer between an execution unit and the write-back arbiter.
// Ready is a function of buffer state and grant only, never of in_valid.
module wb_hold_buf
    import wb_writer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [RAW-1:0]  in_rd,
    input  logic [XLEN-1:0] in_data,
    input  logic            grant,
    output logic            ready,
    output wb_entry_t       entry
);

    // A granted entry leaves on this edge, so the slot can refill on the same edge.
    assign ready = !entry.valid || grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry <= '0;
        end else if (in_valid && ready) begin
            entry <= '{valid: 1'b1, rd: in_rd, data: in_data};
        end else if (grant) begin
            entry.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: merges ALU and LSU results into one registered register-file
// write port with round-robin arbitration. Define WB_SCOREBOARD_EN to build the
// pending-register scoreboard; otherwise pending is tied to zero.
module wb_writer
    import wb_writer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [RAW-1:0]  alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [RAW-1:0]  lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [RAW-1:0]  rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            issue_en,
    input  logic [RAW-1:0]  issue_rd,
    output logic [NREG-1:0] pending
);

    wb_entry_t alu_ent, lsu_ent, win;
    logic      alu_grant, lsu_grant, any_grant, wr_fire, both_full;
    wb_src_t   last_grant;

    wb_hold_buf u_alu_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (alu_valid),
        .in_rd    (alu_rd),
        .in_data  (alu_data),
        .grant    (alu_grant),
        .ready    (alu_ready),
        .entry    (alu_ent)
    );

    wb_hold_buf u_lsu_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (lsu_valid),
        .in_rd    (lsu_rd),
        .in_data  (lsu_data),
        .grant    (lsu_grant),
        .ready    (lsu_ready),
        .entry    (lsu_ent)
    );

    assign both_full = alu_ent.valid && lsu_ent.valid;

    // On a tie the source that did not win the previous tie goes first.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (both_full) begin
            if (last_grant == SRC_ALU) lsu_grant = 1'b1;
            else                       alu_grant = 1'b1;
        end else begin
            alu_grant = alu_ent.valid;
            lsu_grant = lsu_ent.valid;
        end
    end

    assign any_grant = alu_grant || lsu_grant;
    assign win       = lsu_grant ? lsu_ent : alu_ent;
    assign wr_fire   = any_grant && writes_rf(win);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            last_grant <= SRC_ALU;
        end else begin
            rf_we <= wr_fire;
            if (wr_fire) begin
                rf_waddr <= win.rd;
                rf_wdata <= win.data;
            end
            if (both_full) begin
                last_grant <= lsu_grant ? SRC_LSU : SRC_ALU;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NREG-1:0] pend_q, pend_nxt;

    // Set is applied after clear so a re-issue on the retiring edge wins.
    always_comb begin
        pend_nxt = pend_q;
        if (wr_fire) pend_nxt[win.rd] = 1'b0;
        if (issue_en && (issue_rd != '0)) pend_nxt[issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_q <= '0;
        else      pend_q <= pend_nxt;
    end

    assign pending = pend_q;
`else
    logic unused_issue;
    assign unused_issue = ^{issue_en, issue_rd};
    assign pending      = '0;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, rf_waddr, issue_rd;
    logic [31:0] alu_data, lsu_data, rf_wdata, pending;
    logic        rf_we, issue_en;

    int checks   = 0;
    int failures = 0;

    wb_writer dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each source holds at most one result; results retire
    // one per cycle, ties alternate starting with LSU, x0 writes are dropped.
    logic        ma_full, ml_full, m_last_lsu;
    logic [4:0]  ma_rd, ml_rd;
    logic [31:0] ma_data, ml_data;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data, exp_pend;
    logic        a_g, l_g, a_rdy, l_rdy;
    logic [4:0]  g_rd;
    logic [31:0] g_data;

    task automatic model_reset();
        ma_full = 0; ml_full = 0; m_last_lsu = 0;
        ma_rd = 0; ml_rd = 0; ma_data = 0; ml_data = 0;
        exp_we = 0; exp_addr = 0; exp_data = 0; exp_pend = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_we", rf_we, 0);
            check("rst_waddr", rf_waddr, 0);
            check("rst_wdata", rf_wdata, 0);
            check("rst_pending", pending, 0);
            check("rst_alu_ready", alu_ready, 1);
            check("rst_lsu_ready", lsu_ready, 1);
            model_reset();
        end else begin
            if (ma_full && ml_full) begin
                l_g = !m_last_lsu;
                a_g = m_last_lsu;
            end else begin
                a_g = ma_full;
                l_g = ml_full;
            end
            a_rdy = !ma_full || a_g;
            l_rdy = !ml_full || l_g;
            check("alu_ready", alu_ready, a_rdy);
            check("lsu_ready", lsu_ready, l_rdy);
            check("rf_we", rf_we, exp_we);
            if (exp_we) begin
                check("rf_waddr", rf_waddr, exp_addr);
                check("rf_wdata", rf_wdata, exp_data);
            end
            check("pending", pending, exp_pend);

            g_rd   = l_g ? ml_rd : ma_rd;
            g_data = l_g ? ml_data : ma_data;
            exp_we = (a_g || l_g) && (g_rd != 0);
            if (exp_we) begin
                exp_addr = g_rd;
                exp_data = g_data;
            end
`ifdef WB_SCOREBOARD_EN
            if (exp_we) exp_pend[g_rd] = 1'b0;
            if (issue_en && issue_rd != 0) exp_pend[issue_rd] = 1'b1;
`endif
            if (ma_full && ml_full) m_last_lsu = l_g;
            if (alu_valid && a_rdy) begin
                ma_full = 1; ma_rd = alu_rd; ma_data = alu_data;
            end else if (a_g) ma_full = 0;
            if (lsu_valid && l_rdy) begin
                ml_full = 1; ml_rd = lsu_rd; ml_data = lsu_data;
            end else if (l_g) ml_full = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_en = 0; issue_rd = 0;
    endtask

    initial begin
        int n;
        rst = 0;
        idle_inputs();
        repeat (3) tick();
        rst = 1;
        tick();

        // Single ALU write: handshake edge N, write visible after edge N+1.
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 0;
        check("alu_only_early", rf_we, 0);
        tick();
        check("alu_only_we", rf_we, 1);
        check("alu_only_waddr", rf_waddr, 5);
        check("alu_only_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        check("alu_only_pulse", rf_we, 0);

        // Both sources streaming: LSU wins first tie, then strict alternation.
        alu_valid = 1; alu_rd = 1; alu_data = 32'hA0000000;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB0000000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            alu_data = alu_data + 1;
            lsu_data = lsu_data + 1;
            if (k >= 2) begin
                check("stream_we", rf_we, 1);
                check("stream_order", rf_waddr, (k % 2 == 0) ? 2 : 1);
            end
        end
        idle_inputs();
        repeat (3) tick();

        // x0 destination: accepted and retired, never written.
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h12345678;
        check("x0_ready", lsu_ready, 1);
        tick();
        lsu_valid = 0;
        check("x0_ready_grant", lsu_ready, 1);
        tick();
        check("x0_no_we", rf_we, 0);
        check("x0_freed", lsu_ready, 1);
        tick();

        // ALU must get through continuous LSU traffic within two cycles.
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h33333333;
        repeat (3) tick();
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44444444;
        check("fair_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        n = 99;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (n == 99 && rf_we && rf_waddr == 4) n = i;
        end
        check("fair_alu_wait_le2", (n <= 2), 1);
        idle_inputs();
        repeat (3) tick();

        // Issue to x0 never marks anything pending.
        issue_en = 1; issue_rd = 0;
        tick();
        issue_en = 0;
        check("issue_x0", pending, 0);
`ifdef WB_SCOREBOARD_EN
        issue_en = 1; issue_rd = 7;
        tick();
        issue_en = 0;
        check("sb_set", pending, 32'h80);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        tick();
        alu_valid = 0;
        check("sb_hold", pending, 32'h80);
        tick();
        check("sb_clear_we", rf_we, 1);
        check("sb_clear", pending, 0);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
        tick();
        alu_valid = 0;
        issue_en = 1; issue_rd = 7;
        tick();
        issue_en = 0;
        check("sb_reissue_we", rf_we, 1);
        check("sb_reissue", pending, 32'h80);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h79;
        tick();
        alu_valid = 0;
        tick();
        check("sb_final_clear", pending, 0);
`else
        issue_en = 1; issue_rd = 7;
        tick();
        issue_en = 0;
        check("sb_absent", pending, 0);
`endif
        tick();

        // Async reset with both buffers full and a write in flight.
        alu_valid = 1; alu_rd = 9;  alu_data = 32'h99999999;
        lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hAAAAAAAA;
        tick();
        tick();
        check("pre_rst_we", rf_we, 1);
        #2 rst = 0;
        #1;
        check("async_we", rf_we, 0);
        check("async_waddr", rf_waddr, 0);
        check("async_wdata", rf_wdata, 0);
        idle_inputs();
        tick();
        tick();
        rst = 1;
        check("post_rst_alu_ready", alu_ready, 1);
        check("post_rst_lsu_ready", lsu_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_we", rf_we, 0);
        end

        // Randomized traffic; the negedge process checks every cycle.
        for (int i = 0; i < 800; i++) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            lsu_valid = ($urandom_range(0, 3) != 0);
            lsu_rd    = 5'($urandom_range(0, 7));
            lsu_data  = $urandom;
            issue_en  = ($urandom_range(0, 2) == 0);
            issue_rd  = 5'($urandom_range(0, 7));
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 XLEN, 32, data width of write-back results and register-file write data.
REQ-002 NREG, 32, number of architectural registers; address width is 5.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 alu_valid/alu_ready/alu_rd/alu_data  in/out/in/in  1/1/5/XLEN  ALU result handshake, destination, value.
REQ-006 lsu_valid/lsu_ready/lsu_rd/lsu_data  in/out/in/in  1/1/5/XLEN  load-unit result handshake, destination, value.
REQ-007 rf_we/rf_waddr/rf_wdata  out/out/out  1/5/XLEN  registered register-file write port.
REQ-008 issue_en/issue_rd  in/in  1/5  decode marks destination register outdated (scoreboard builds only).
REQ-009 pending  out  NREG  per-register outdated bitmap (scoreboard builds only).

Function
REQ-010 Each source SHALL own a one-entry holding buffer (valid, rd, data); transfer occurs on an edge where valid && ready.
REQ-011 src_ready SHALL be high when its buffer is empty or is granted this cycle; it SHALL NOT depend combinationally on src_valid.
REQ-012 Per cycle the arbiter SHALL grant at most one full buffer: one full buffer wins alone; when both are full, the source not granted last SHALL win (round-robin).
REQ-013 On the edge after a grant, rf_we/rf_waddr/rf_wdata SHALL present the granted entry for exactly one cycle; otherwise rf_we=0 with waddr/wdata holding prior values.
REQ-014 Latency: handshake at edge N, grant in cycle N..N+1, rf_we high in cycle following edge N+1; register file captures at edge N+2.
REQ-015 An entry with rd=0 SHALL be granted and freed normally but produce rf_we=0 (x0 never written).
REQ-016 A buffer granted and refilled on the same edge SHALL hold the new entry; sustained throughput of one write per cycle SHALL be achieved.
REQ-017 The last-grant flag SHALL update only on a grant where both buffers were full.

Reset
REQ-018 rst low SHALL clear both buffers, rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, last-grant=ALU (LSU wins first tie).
REQ-019 Reset mid-operation SHALL discard buffered entries without issuing writes; outputs reach reset values asynchronously.

Configuration
REQ-020 Macro WB_SCOREBOARD_EN SHALL compile in the scoreboard: issue_en with issue_rd!=0 sets pending[issue_rd] at the edge; a granted entry with rd!=0 clears pending[rd] on the edge it loads the output register.
REQ-021 With WB_SCOREBOARD_EN, simultaneous set and clear of the same bit SHALL leave it set; pending[0] SHALL be constant 0.
REQ-022 Without WB_SCOREBOARD_EN, issue_en/issue_rd SHALL be ignored and pending SHALL be tied to 0.

Structure
REQ-023 XLEN, register-address width, NREG and the write-back entry struct (valid, rd, data) SHALL live in the shared core package.
REQ-024 The holding buffer SHALL be one sub-module wb_hold_buf, instantiated per source; arbiter, output register and scoreboard stay in wb_writer.

Verification
REQ-025 ALU only: alu rd=5 data=0xDEADBEEF accepted edge N -> rf_we=1, waddr=5, wdata=0xDEADBEEF after edge N+1, single cycle.
REQ-026 Both sources valid every cycle (ALU rd=1, LSU rd=2) -> writes alternate 2,1,2,1; one write every cycle; no entry lost or duplicated.
REQ-027 LSU rd=0 data=0x12345678 -> lsu_ready pulses, rf_we stays 0, buffer frees.
REQ-028 rf held by continuous LSU traffic while ALU waits -> ALU granted within 2 cycles; alu_ready low while its buffer full and ungranted.
REQ-029 WB_SCOREBOARD_EN: issue rd=7 -> pending=0x80; ALU rd=7 written -> bit clears same edge as rf_we loads; issue rd=7 on that edge -> bit stays set.
REQ-030 rst low with both buffers full -> no rf_we ever issued for those entries; all outputs 0; readys high after release.
